calc_operand_sequencer: RTL and testbench
=========================================

Name: calc_operand_sequencer

Overview:
- Front-end control stage of the calculator datapath, directly upstream of the 3-bit sign-magnitude add/subtract unit.
- Debounces a single Enter push-button and walks the user through a fixed entry sequence: operand A, then operation, then operand B.
- Drives the adder's a1/b1/Add_Sub inputs from registers, waits one cycle for the combinational result, then latches sf/sign into a held result register for the display stage.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable synchronized cycles needed to accept a new Enter level (20 ms at 50 MHz); must be >= 2.
- CNT_W, 20, debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- btn_enter  input  1  raw, asynchronous, bouncing Enter button; active-high.
- btn_clear  input  1  synchronous clear, already debounced by the board logic; active-high.
- sw_val  input  3  switch operand in sign-magnitude: [2]=sign, [1:0]=magnitude.
- op_sel  input  1  operation switch: 0=add, 1=subtract.
- a1  output  3  registered operand A to the adder.
- b1  output  3  registered operand B to the adder.
- add_sub  output  1  registered operation to the adder's Add_Sub input.
- sf_in  input  3  adder magnitude result, combinational from a1/b1/add_sub.
- sign_in  input  1  adder sign result.
- res_mag  output  3  latched result magnitude.
- res_sign  output  1  latched result sign; forced 0 when res_mag==0.
- res_valid  output  1  high while a latched result is held (state RES).
- stage  output  2  current FSM state encoding, for display prompts.

Behaviour:
- Reset (rst_n=0, asynchronous): a1=b1=0, add_sub=0, res_mag=0, res_sign=0, res_valid=0, state=GET_A (stage=0). Synchronizer, debounced level and counter all cleared. Reset mid-sequence discards every captured value.
- Input synchronizer: btn_enter passes through a 2-flop synchronizer.
- Debounce: a counter increments while the synchronized level differs from the debounced level and clears when they match. On reaching DEBOUNCE_CYCLES, the debounced level takes the synchronized value and the counter clears.
- Enter pulse: enter_p is a one-cycle pulse on each 0->1 transition of the debounced level. Release never pulses. Holding the button produces exactly one pulse.
- Operand capture normalisation: a captured value with magnitude 0 is stored as 3'b000. Negative zero never reaches the adder.
- FSM states and encodings: GET_A=0, GET_OP=1, GET_B=2, EXEC=3, RES=3. RES is distinguished from EXEC by res_valid.
- GET_A: on enter_p, a1<=norm(sw_val), go to GET_OP.
- GET_OP: on enter_p, add_sub<=op_sel, go to GET_B.
- GET_B: on enter_p, b1<=norm(sw_val), go to EXEC.
- EXEC: unconditional, one cycle.
  - res_mag<=sf_in.
  - res_sign<=sign_in & (sf_in!=0).
  - res_valid<=1.
  - Go to RES.
- RES: outputs held.
  - On enter_p: res_valid<=0, go to GET_A. a1, b1 and add_sub keep their old values until overwritten.
- Latency: the enter_p that captures B occurs in cycle n. b1 is updated at edge n+1 (EXEC). The result is latched and res_valid rises at edge n+2.
- btn_clear: in any state, return to GET_A at the next edge with res_valid=0. res_mag, res_sign, a1, b1 and add_sub keep their values. Clear has priority over a simultaneous enter_p, and that enter_p is lost.
- enter_p arriving during EXEC is ignored.
- Operand switches are sampled only on the enter_p cycle. Switch changes at other times have no effect.

Test Plan (DEBOUNCE_CYCLES=4, CNT_W=3, bench models the adder behaviourally):
- Reset: assert rst_n=0 mid-GET_B with a1=3'b011 -> all outputs 0 and stage=0 immediately, without waiting for a clock edge.
- Debounce: toggle btn_enter 0/1 every 2 cycles for 20 cycles, then hold 1 -> exactly one enter_p, 6 cycles after the steady hold (2 sync + 4 stable), state GET_A->GET_OP.
- Full add sequence: A=3'b010 (+2), op=0, B=3'b111 (-3) -> a1=010, b1=111, add_sub=0. Two edges after the B press: res_mag=1, res_sign=1, res_valid=1.
- Subtract to zero: A=3'b001, op=1, B=3'b001 -> res_mag=0, res_sign=0. Also A=3'b100 (-0) -> a1 captured as 000.
- Clear priority: btn_clear and enter_p in the same cycle in GET_OP -> next state GET_A, add_sub unchanged. Clear in RES -> res_valid=0, res_mag held.
- Wrap: press Enter in RES -> res_valid=0, stage=0. A new sequence A=3'b011, op=1, B=3'b110 (-2) -> res_mag=5 truncated per adder 3-bit sf (adder output 101), res_sign=0.

Source files
------------

// File: rtl/calc_operand_sequencer_if.sv
// Calculator front-end bus: button/switch inputs, adder operand/result handshake, held result.
// Pure wiring, no latency; no backpressure (the adder result is combinational from the operands).
// The slave modport is the sequencer side; the master modport is the board/adder side.
interface calc_operand_sequencer_if;
    logic       btn_enter;
    logic       btn_clear;
    logic [2:0] sw_val;
    logic       op_sel;
    logic [2:0] a1;
    logic [2:0] b1;
    logic       add_sub;
    logic [2:0] sf_in;
    logic       sign_in;
    logic [2:0] res_mag;
    logic       res_sign;
    logic       res_valid;
    logic [1:0] stage;

    modport master (
        output btn_enter, btn_clear, sw_val, op_sel, sf_in, sign_in,
        input  a1, b1, add_sub, res_mag, res_sign, res_valid, stage
    );

    modport slave (
        input  btn_enter, btn_clear, sw_val, op_sel, sf_in, sign_in,
        output a1, b1, add_sub, res_mag, res_sign, res_valid, stage
    );
endinterface

// File: rtl/calc_operand_sequencer.sv
// Debounced Enter sequencer: captures operand A, operation, operand B, then latches the adder result.
// Latency: Enter accepted 2 sync + DEBOUNCE_CYCLES cycles after a stable press; result held 2 edges after B.
// No backpressure: the held result stays until Enter or Clear; Clear beats a same-cycle Enter.
module calc_operand_sequencer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic                    clk,
    input  logic                    rst_n,
    calc_operand_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_GET_A  = 3'd0,
        S_GET_OP = 3'd1,
        S_GET_B  = 3'd2,
        S_EXEC   = 3'd3,
        S_RES    = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] sync_q, sync_d;
    logic       deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic       enter_p;
    logic [2:0] a1_q, a1_d, b1_q, b1_d, res_mag_q, res_mag_d;
    logic       add_sub_q, add_sub_d, res_sign_q, res_sign_d, res_valid_q, res_valid_d;
    logic [1:0] stage;

    // Negative zero is folded to +0 so the adder never sees 3'b100.
    function automatic logic [2:0] norm(input logic [2:0] v);
        return (v[1:0] == 2'b00) ? 3'b000 : v;
    endfunction

    // enter_p fires in the cycle the debounced level is about to rise.
    always_comb begin
        sync_d  = {sync_q[0], bus.btn_enter};
        deb_d   = deb_q;
        cnt_d   = '0;
        enter_p = 1'b0;
        if (sync_q[1] != deb_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                deb_d   = sync_q[1];
                enter_p = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.btn_clear) begin
            state_d = S_GET_A;
        end else begin
            case (state_q)
                S_GET_A:  if (enter_p) state_d = S_GET_OP;
                S_GET_OP: if (enter_p) state_d = S_GET_B;
                S_GET_B:  if (enter_p) state_d = S_EXEC;
                S_EXEC:   state_d = S_RES;
                S_RES:    if (enter_p) state_d = S_GET_A;
                default:  state_d = S_GET_A;
            endcase
        end
    end

    always_comb begin
        a1_d        = a1_q;
        b1_d        = b1_q;
        add_sub_d   = add_sub_q;
        res_mag_d   = res_mag_q;
        res_sign_d  = res_sign_q;
        res_valid_d = res_valid_q;
        stage       = (state_q == S_RES) ? 2'd3 : state_q[1:0];
        if (bus.btn_clear) begin
            res_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_GET_A:  if (enter_p) a1_d = norm(bus.sw_val);
                S_GET_OP: if (enter_p) add_sub_d = bus.op_sel;
                S_GET_B:  if (enter_p) b1_d = norm(bus.sw_val);
                S_EXEC: begin
                    res_mag_d   = bus.sf_in;
                    res_sign_d  = bus.sign_in & (bus.sf_in != 3'b000);
                    res_valid_d = 1'b1;
                end
                S_RES:    if (enter_p) res_valid_d = 1'b0;
                default:  res_valid_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_GET_A;
            sync_q      <= '0;
            deb_q       <= 1'b0;
            cnt_q       <= '0;
            a1_q        <= '0;
            b1_q        <= '0;
            add_sub_q   <= 1'b0;
            res_mag_q   <= '0;
            res_sign_q  <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            deb_q       <= deb_d;
            cnt_q       <= cnt_d;
            a1_q        <= a1_d;
            b1_q        <= b1_d;
            add_sub_q   <= add_sub_d;
            res_mag_q   <= res_mag_d;
            res_sign_q  <= res_sign_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign bus.a1        = a1_q;
    assign bus.b1        = b1_q;
    assign bus.add_sub   = add_sub_q;
    assign bus.res_mag   = res_mag_q;
    assign bus.res_sign  = res_sign_q;
    assign bus.res_valid = res_valid_q;
    assign bus.stage     = stage;

endmodule

// File: tb/tb_calc_operand_sequencer.sv
// Bench for calc_operand_sequencer with a behavioural sign-magnitude adder closing the loop.
module tb_calc_operand_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    calc_operand_sequencer_if bus ();

    calc_operand_sequencer #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    function automatic int sm_val(input logic [2:0] v);
        return v[2] ? -int'(v[1:0]) : int'(v[1:0]);
    endfunction

    // Adder model deliberately reports sign=1 on a zero difference, so the sequencer's zero-sign masking is exercised.
    int add_va, add_vb, add_r;
    always_comb begin
        add_va = sm_val(bus.a1);
        add_vb = sm_val(bus.b1);
        if (bus.add_sub) add_vb = -add_vb;
        add_r       = add_va + add_vb;
        bus.sf_in   = 3'((add_r < 0) ? -add_r : add_r);
        bus.sign_in = (add_r < 0) || (add_r == 0 && bus.add_sub);
    end

    typedef struct {
        logic [2:0] mag;
        logic       sign;
    } res_t;
    res_t exp_q[$];

    typedef struct {
        logic [2:0] a;
        logic       op;
        logic [2:0] b;
        logic [2:0] exp_a1;
        logic [2:0] exp_b1;
        logic [2:0] exp_mag;
        logic       exp_sign;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic rv_prev = 1'b0;
    always @(negedge clk) begin
        if (bus.res_valid && !rv_prev) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_result", exp_q.size(), 1);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                chk("sb_res_mag", int'(bus.res_mag), int'(e.mag));
                chk("sb_res_sign", int'(bus.res_sign), int'(e.sign));
            end
        end
        rv_prev = bus.res_valid;
    end

    task automatic press(input logic [2:0] sw, input logic op);
        bus.sw_val    = sw;
        bus.op_sel    = op;
        bus.btn_enter = 1'b1;
        repeat (8) step();
        bus.btn_enter = 1'b0;
        bus.sw_val    = ~sw;
        bus.op_sel    = ~op;
        repeat (8) step();
    endtask

    // B press checked edge by edge: EXEC one edge after enter_p, result held the edge after.
    task automatic press_b(input logic [2:0] sw, input logic [2:0] exp_b1);
        bus.sw_val    = sw;
        bus.btn_enter = 1'b1;
        repeat (5) step();
        chk("b_pre_stage", int'(bus.stage), 2);
        step();
        chk("exec_stage", int'(bus.stage), 3);
        chk("exec_res_valid", int'(bus.res_valid), 0);
        chk("exec_b1", int'(bus.b1), int'(exp_b1));
        step();
        chk("res_valid_rise", int'(bus.res_valid), 1);
        step();
        bus.btn_enter = 1'b0;
        bus.sw_val    = ~sw;
        repeat (8) step();
    endtask

    initial begin
        vec_t vecs[6];
        int   bounced;
        int   lat;
        vecs[0] = '{3'b010, 1'b0, 3'b111, 3'b010, 3'b111, 3'd1, 1'b1};
        vecs[1] = '{3'b001, 1'b1, 3'b001, 3'b001, 3'b001, 3'd0, 1'b0};
        vecs[2] = '{3'b100, 1'b0, 3'b011, 3'b000, 3'b011, 3'd3, 1'b0};
        vecs[3] = '{3'b011, 1'b1, 3'b110, 3'b011, 3'b110, 3'd5, 1'b0};
        vecs[4] = '{3'b111, 1'b1, 3'b011, 3'b111, 3'b011, 3'd6, 1'b1};
        vecs[5] = '{3'b101, 1'b0, 3'b100, 3'b101, 3'b000, 3'd1, 1'b1};

        rst_n         = 1'b0;
        bus.btn_enter = 1'b0;
        bus.btn_clear = 1'b0;
        bus.sw_val    = 3'b000;
        bus.op_sel    = 1'b0;
        repeat (2) step();
        chk("rst_a1", int'(bus.a1), 0);
        chk("rst_b1", int'(bus.b1), 0);
        chk("rst_add_sub", int'(bus.add_sub), 0);
        chk("rst_res_mag", int'(bus.res_mag), 0);
        chk("rst_res_valid", int'(bus.res_valid), 0);
        chk("rst_stage", int'(bus.stage), 0);
        rst_n = 1'b1;
        step();

        // Bounce: every 2 cycles, ending low, then a steady hold.
        bounced = 0;
        for (int i = 0; i < 10; i++) begin
            bus.btn_enter = (i % 2 == 0);
            repeat (2) begin
                step();
                if (bus.stage != 2'd0) bounced++;
            end
        end
        chk("bounce_no_pulse", bounced, 0);
        bus.sw_val    = 3'b110;
        bus.btn_enter = 1'b1;
        lat = 0;
        while (bus.stage == 2'd0 && lat < 20) begin
            step();
            lat++;
        end
        chk("debounce_latency", lat, 6);
        chk("debounce_a1", int'(bus.a1), 6);
        repeat (10) step();
        chk("hold_single_pulse", int'(bus.stage), 1);
        bus.btn_enter = 1'b0;
        bus.sw_val    = 3'b001;
        repeat (8) step();
        chk("release_no_pulse", int'(bus.stage), 1);
        chk("a1_ignores_switch", int'(bus.a1), 6);

        // Clear coincident with enter_p in GET_OP.
        bus.op_sel    = 1'b1;
        bus.btn_enter = 1'b1;
        repeat (5) step();
        bus.btn_clear = 1'b1;
        step();
        bus.btn_clear = 1'b0;
        chk("clr_prio_stage", int'(bus.stage), 0);
        chk("clr_prio_add_sub", int'(bus.add_sub), 0);
        repeat (6) step();
        chk("clr_enter_lost", int'(bus.stage), 0);
        bus.btn_enter = 1'b0;
        repeat (8) step();

        // Asynchronous reset mid-GET_B.
        press(3'b011, 1'b0);
        press(3'b000, 1'b1);
        chk("pre_rst_stage", int'(bus.stage), 2);
        chk("pre_rst_a1", int'(bus.a1), 3);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_a1", int'(bus.a1), 0);
        chk("arst_add_sub", int'(bus.add_sub), 0);
        chk("arst_stage", int'(bus.stage), 0);
        chk("arst_res_valid", int'(bus.res_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            press(vecs[i].a, 1'b0);
            chk("v_a1", int'(bus.a1), int'(vecs[i].exp_a1));
            chk("v_stage_op", int'(bus.stage), 1);
            press(3'b101, vecs[i].op);
            chk("v_add_sub", int'(bus.add_sub), int'(vecs[i].op));
            chk("v_a1_held", int'(bus.a1), int'(vecs[i].exp_a1));
            exp_q.push_back('{vecs[i].exp_mag, vecs[i].exp_sign});
            press_b(vecs[i].b, vecs[i].exp_b1);
            chk("v_res_mag", int'(bus.res_mag), int'(vecs[i].exp_mag));
            chk("v_res_sign", int'(bus.res_sign), int'(vecs[i].exp_sign));
            chk("v_res_stage", int'(bus.stage), 3);
            chk("v_res_valid", int'(bus.res_valid), 1);
            if (i < 5) begin
                press(3'b000, 1'b0);
                chk("wrap_res_valid", int'(bus.res_valid), 0);
                chk("wrap_stage", int'(bus.stage), 0);
                chk("wrap_res_mag_held", int'(bus.res_mag), int'(vecs[i].exp_mag));
            end
        end

        // Clear while holding a result.
        bus.btn_clear = 1'b1;
        step();
        bus.btn_clear = 1'b0;
        chk("clr_res_valid", int'(bus.res_valid), 0);
        chk("clr_res_stage", int'(bus.stage), 0);
        chk("clr_res_mag_held", int'(bus.res_mag), 1);
        chk("clr_b1_held", int'(bus.b1), 0);
        repeat (2) step();
        chk("sb_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
